// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// sound_pkg - constants and types shared by the APU sound blocks. Rev 1.0
// ============================================================================
package sound_pkg;

  localparam int SEQ_PRESCALE_512HZ = 64453;

  // Bit n set means step n issues that strobe.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  typedef logic [2:0] seq_step_t;

endpackage
`default_nettype wire

// File: rtl/sound_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// sound_frame_sequencer_if - enable/status inputs and tick outputs. Rev 1.0
// ============================================================================
interface sound_frame_sequencer_if;
  import sound_pkg::*;

  logic      I_SOUND_EN;
  logic [3:0] I_CH_ACTIVE;
  logic      I_DIV_BIT;
  logic      O_LENGTH_TICK;
  logic      O_SWEEP_TICK;
  logic      O_ENVELOPE_TICK;
  seq_step_t O_STEP;
  logic      O_CH_KILL;
  logic [7:0] O_NR52_DATA;

  modport master (
    output I_SOUND_EN, I_CH_ACTIVE, I_DIV_BIT,
    input  O_LENGTH_TICK, O_SWEEP_TICK, O_ENVELOPE_TICK, O_STEP, O_CH_KILL, O_NR52_DATA
  );

  modport slave (
    input  I_SOUND_EN, I_CH_ACTIVE, I_DIV_BIT,
    output O_LENGTH_TICK, O_SWEEP_TICK, O_ENVELOPE_TICK, O_STEP, O_CH_KILL, O_NR52_DATA
  );
endinterface
`default_nettype wire

// File: rtl/sound_seq_prescaler.sv
`default_nettype none
// ============================================================================
// sound_seq_prescaler - one-cycle 512 Hz advance pulse; DIV falling-edge
// detector instead when SOUND_SEQ_DIV_SYNC_EN is defined. Rev 1.0
// ============================================================================
module sound_seq_prescaler #(
  parameter int PRESCALE = 64453,
  parameter int CNT_W    = 17
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
`ifdef SOUND_SEQ_DIV_SYNC_EN
  input  wire logic i_div_bit,
`endif
  output logic      o_advance
);

`ifdef SOUND_SEQ_DIV_SYNC_EN
  // Tracks the DIV tap even while disabled so a rising enable sees no false edge.
  logic r_div_prev;

  always_ff @(posedge clk) begin
    if (rst) r_div_prev <= 1'b0;
    else     r_div_prev <= i_div_bit;
  end

  assign o_advance = i_en & r_div_prev & ~i_div_bit;
`else
  logic [CNT_W-1:0] r_cnt;
  logic             r_en_d;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(PRESCALE - 1));

  // The first enabled cycle only arms the counter, so the first advance lands PRESCALE cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= i_en;
      if (!i_en)       r_cnt <= '0;
      else if (r_en_d) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_advance = i_en & r_en_d & w_wrap;
`endif

endmodule
`default_nettype wire

// File: rtl/sound_frame_sequencer.sv
`default_nettype none
// ============================================================================
// sound_frame_sequencer - length/sweep/envelope tick scheduler and NR52 gating.
// Optional macro: SOUND_SEQ_DIV_SYNC_EN (advance on DIV falling edge). Rev 1.0
// ============================================================================
module sound_frame_sequencer
  import sound_pkg::*;
#(
  parameter int PRESCALE = SEQ_PRESCALE_512HZ,
  parameter int CNT_W    = 17
) (
  input  wire logic              I_CLK,
  input  wire logic              I_RESET,
  sound_frame_sequencer_if.slave bus
);

  logic      w_advance;
  seq_step_t r_step;
  seq_step_t r_out_step;
  logic      r_len;
  logic      r_sweep;
  logic      r_env;
  logic      r_kill;

  sound_seq_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk       (I_CLK),
    .rst       (I_RESET),
    .i_en      (bus.I_SOUND_EN),
`ifdef SOUND_SEQ_DIV_SYNC_EN
    .i_div_bit (bus.I_DIV_BIT),
`endif
    .o_advance (w_advance)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_step     <= '0;
      r_out_step <= '0;
      r_len      <= 1'b0;
      r_sweep    <= 1'b0;
      r_env      <= 1'b0;
      r_kill     <= 1'b1;
    end else begin
      r_len   <= 1'b0;
      r_sweep <= 1'b0;
      r_env   <= 1'b0;
      r_kill  <= ~bus.I_SOUND_EN;
      if (!bus.I_SOUND_EN) begin
        r_step <= '0;
      end else if (w_advance) begin
        r_len      <= LEN_STEPS[r_step];
        r_sweep    <= SWEEP_STEPS[r_step];
        r_env      <= ENV_STEPS[r_step];
        r_out_step <= r_step;
        r_step     <= r_step + 3'd1;
      end
    end
  end

  assign bus.O_LENGTH_TICK   = r_len;
  assign bus.O_SWEEP_TICK    = r_sweep;
  assign bus.O_ENVELOPE_TICK = r_env;
  assign bus.O_STEP          = r_out_step;
  assign bus.O_CH_KILL       = r_kill;
  assign bus.O_NR52_DATA     = {bus.I_SOUND_EN, 3'b111, bus.I_CH_ACTIVE & {4{bus.I_SOUND_EN}}};

endmodule
`default_nettype wire
